// File: rtl/ram_seq_pkg.sv
// ----------------------------------------------------------------------------
// ram_seq_pkg
// Shared types and constants for the RAM host sequencer.
//   state_t  : sequencer FSM states
//   RAM_AW   : byte address width of the RAM wrapper
//   OP_BIT   : bit of the header byte that selects write (1) / read (0)
//   LEN_W    : width of the burst length field
// ----------------------------------------------------------------------------
package ram_seq_pkg;

   localparam int RAM_AW = 7;
   localparam int OP_BIT = 7;
   localparam int LEN_W  = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_LEN  = 3'd1,
      WR_DATA  = 3'd2,
      WR_ISSUE = 3'd3,
      RD_ISSUE = 3'd4,
      RD_WAIT  = 3'd5,
      RD_HOLD  = 3'd6
   } state_t;

endpackage

// File: rtl/ram_host_sequencer_if.sv
// ----------------------------------------------------------------------------
// ram_host_sequencer_if
// Bundles the host byte streams and the RAM wrapper pins of the sequencer.
//   cmd_data/cmd_valid/cmd_ready : host -> sequencer byte stream
//   rsp_data/rsp_valid/rsp_ready : sequencer -> host read-byte stream
//   ram_ui_in/ram_uio_in/ram_uo_out/ram_rst_n : wrapper pins
//   busy      : sequencer is not idle
//   dbg_state : current FSM state, for observation only
// Modports: master = the sequencer, slave = host/RAM side.
//
// Handshake rule for both streams: a byte moves on a rising clk edge where
// valid and ready are both high. The source holds data stable and keeps
// valid high until that edge; ready may change freely and never depends on
// the same cycle's valid.
// ----------------------------------------------------------------------------
interface ram_host_sequencer_if;
   import ram_seq_pkg::*;

   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] ram_ui_in;
   logic [7:0] ram_uio_in;
   logic [7:0] ram_uo_out;
   logic       ram_rst_n;
   logic       busy;
   state_t     dbg_state;

   modport master (
      input  cmd_data, cmd_valid, rsp_ready, ram_uo_out,
      output cmd_ready, rsp_data, rsp_valid, ram_ui_in, ram_uio_in,
             ram_rst_n, busy, dbg_state
   );

   modport slave (
      output cmd_data, cmd_valid, rsp_ready, ram_uo_out,
      input  cmd_ready, rsp_data, rsp_valid, ram_ui_in, ram_uio_in,
             ram_rst_n, busy, dbg_state
   );

endinterface

// File: rtl/ram_host_sequencer.sv
// ----------------------------------------------------------------------------
// ram_host_sequencer
// Turns framed host bytes into burst writes/reads on a byte-lane RAM
// wrapper and returns read bytes on a response stream.
//   Frame: {op, start_addr[6:0]}, L, then L+1 data bytes for writes.
//   The burst moves L+1 bytes; the 7-bit address wraps 127 -> 0.
// Ports:
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : ram_host_sequencer_if.master (host streams + wrapper pins)
// Parameter:
//   RD_LAT : cycles from read address on ram_ui_in to ram_uo_out valid (1..3)
// ----------------------------------------------------------------------------
module ram_host_sequencer
   import ram_seq_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   ram_host_sequencer_if.master bus
);

   state_t              state, state_n;
   logic [RAM_AW-1:0]   addr, addr_n;
   logic [LEN_W-1:0]    cnt, cnt_n;
   logic                op, op_n;
   logic [1:0]          lat_cnt, lat_n;
   logic [7:0]          ui_q, ui_n;
   logic [7:0]          uio_q, uio_n;
   logic [7:0]          rsp_data_q, rsp_data_n;
   logic                rsp_valid_q, rsp_valid_n;
   logic                busy_q, busy_n;
   logic                cmd_ready;
   logic                accept;

   // Host bytes are only taken while parsing a frame or collecting write data.
   assign cmd_ready = (state == IDLE) || (state == GET_LEN) || (state == WR_DATA);
   assign accept    = bus.cmd_valid && cmd_ready;

   always_comb begin
      state_n     = state;
      addr_n      = addr;
      cnt_n       = cnt;
      op_n        = op;
      lat_n       = lat_cnt;
      // WE defaults low; the address/data lanes keep their last value so the
      // wrapper's byte select never glitches.
      ui_n        = {1'b0, ui_q[6:0]};
      uio_n       = uio_q;
      rsp_data_n  = rsp_data_q;
      rsp_valid_n = rsp_valid_q;

      case (state)
         IDLE: begin
            if (accept) begin
               addr_n  = bus.cmd_data[RAM_AW-1:0];
               op_n    = bus.cmd_data[OP_BIT];
               state_n = GET_LEN;
            end
         end
         GET_LEN: begin
            if (accept) begin
               cnt_n   = bus.cmd_data;
               state_n = op ? WR_DATA : RD_ISSUE;
            end
         end
         WR_DATA: begin
            if (accept) begin
               ui_n    = {1'b1, addr};
               uio_n   = bus.cmd_data;
               state_n = WR_ISSUE;
            end
         end
         WR_ISSUE: begin
            // WE was raised on entry; the default above drops it at this edge.
            addr_n = addr + 1'b1;
            if (cnt == '0) begin
               state_n = IDLE;
            end else begin
               cnt_n   = cnt - 1'b1;
               state_n = WR_DATA;
            end
         end
         RD_ISSUE: begin
            ui_n    = {1'b0, addr};
            lat_n   = 2'(RD_LAT);
            state_n = RD_WAIT;
         end
         RD_WAIT: begin
            // RD_WAIT lasts RD_LAT cycles; capture on the last of them.
            if (lat_cnt <= 2'd1) begin
               rsp_data_n  = bus.ram_uo_out;
               rsp_valid_n = 1'b1;
               state_n     = RD_HOLD;
            end else begin
               lat_n = lat_cnt - 1'b1;
            end
         end
         RD_HOLD: begin
            if (bus.rsp_ready) begin
               rsp_valid_n = 1'b0;
               addr_n      = addr + 1'b1;
               if (cnt == '0) begin
                  state_n = IDLE;
               end else begin
                  cnt_n   = cnt - 1'b1;
                  state_n = RD_ISSUE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // busy is registered from the next state so it lines up with state.
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr        <= '0;
         cnt         <= '0;
         op          <= 1'b0;
         lat_cnt     <= '0;
         ui_q        <= 8'h00;
         uio_q       <= 8'h00;
         rsp_data_q  <= 8'h00;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_n;
         addr        <= addr_n;
         cnt         <= cnt_n;
         op          <= op_n;
         lat_cnt     <= lat_n;
         ui_q        <= ui_n;
         uio_q       <= uio_n;
         rsp_data_q  <= rsp_data_n;
         rsp_valid_q <= rsp_valid_n;
         busy_q      <= busy_n;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.ram_ui_in  = ui_q;
   assign bus.ram_uio_in = uio_q;
   assign bus.ram_rst_n  = ~rst;
   assign bus.busy       = busy_q;
   assign bus.dbg_state  = state;

endmodule

// File: tb/tb_ram_host_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ram_host_sequencer
// Directed bench for ram_host_sequencer with a behavioural RAM wrapper,
// a frame-level reference memory and expected-write / expected-response
// queues checked every cycle.
// ----------------------------------------------------------------------------
module tb_ram_host_sequencer;
   import ram_seq_pkg::*;

   localparam int RD_LAT = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_host_sequencer_if bus();

   ram_host_sequencer #(.RD_LAT(RD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- RAM wrapper model ----------------
   // Registered write on WE, combinational read of the addressed byte.
   logic [7:0] ram_mem [0:127] = '{default: 8'h00};
   always @(posedge clk) begin
      if (bus.ram_rst_n && bus.ram_ui_in[7])
         ram_mem[bus.ram_ui_in[6:0]] <= bus.ram_uio_in;
   end
   assign bus.ram_uo_out = ram_mem[bus.ram_ui_in[6:0]];

   // ---------------- scoreboard ----------------
   logic [14:0] exp_q[$];       // expected write pulses {addr, data}
   logic [7:0]  exp_rsp_q[$];   // expected response bytes
   logic [14:0] obs_wr_q[$];
   logic [7:0]  obs_rsp_q[$];
   logic [7:0]  ref_mem [0:127] = '{default: 8'h00};
   logic [7:0]  wdata [0:255];
   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      check_cnt++;
      $display("FAIL %s: event did not occur in its cycle budget", name);
   endtask

   // Per-cycle compare, sampled on the falling edge.
   logic       prev_we   = 1'b0;
   logic       prev_hold = 1'b0;
   logic       prev_rst  = 1'b0;
   logic [7:0] prev_rsp  = 8'h00;
   logic [14:0] e_wr;
   logic [7:0]  e_rsp;

   always @(negedge clk) begin
      if (bus.ram_ui_in[7]) begin
         check("we_single_cycle", {31'd0, prev_we}, 32'd0);
         if (exp_q.size() == 0) begin
            fail_now("unexpected_write");
         end else begin
            e_wr = exp_q.pop_front();
            check("write_addr", {25'd0, bus.ram_ui_in[6:0]}, {25'd0, e_wr[14:8]});
            check("write_data", {24'd0, bus.ram_uio_in}, {24'd0, e_wr[7:0]});
         end
         obs_wr_q.push_back({bus.ram_ui_in[6:0], bus.ram_uio_in});
      end
      if (prev_hold && !prev_rst) begin
         check("rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
         check("rsp_data_stable", {24'd0, bus.rsp_data}, {24'd0, prev_rsp});
      end
      if (bus.rsp_valid && !rst) begin
         check("cmd_ready_during_read", {31'd0, bus.cmd_ready}, 32'd0);
         if (bus.rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
               fail_now("unexpected_rsp");
            end else begin
               e_rsp = exp_rsp_q.pop_front();
               check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e_rsp});
            end
            obs_rsp_q.push_back(bus.rsp_data);
         end
      end
      prev_we   = bus.ram_ui_in[7];
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp  = bus.rsp_data;
      prev_rst  = rst;
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.cmd_data  = b;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.cmd_ready) fail_now("cmd_accept");
      else begin
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic write_frame(input logic [6:0] a, input logic [7:0] l);
      logic [6:0] ai;
      for (int i = 0; i <= int'(l); i++) begin
         ai = a + 7'(i);
         exp_q.push_back({ai, wdata[i]});
         ref_mem[ai] = wdata[i];
      end
      send_byte({1'b1, a});
      send_byte(l);
      for (int i = 0; i <= int'(l); i++) send_byte(wdata[i]);
   endtask

   task automatic read_frame(input logic [6:0] a, input logic [7:0] l);
      logic [6:0] ai;
      for (int i = 0; i <= int'(l); i++) begin
         ai = a + 7'(i);
         exp_rsp_q.push_back(ref_mem[ai]);
      end
      send_byte({1'b0, a});
      send_byte(l);
   endtask

   task automatic wait_idle(input int budget, output int cycles);
      cycles = 0;
      while (bus.busy && cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (bus.busy) fail_now("wait_idle");
      check("wr_queue_drained", exp_q.size(), 32'd0);
      check("rsp_queue_drained", exp_rsp_q.size(), 32'd0);
   endtask

   task automatic clear_obs();
      obs_wr_q.delete();
      obs_rsp_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   logic [14:0] lit_wr [0:3];
   logic [7:0]  lit_rsp [0:3];
   int cyc;

   initial begin
      rst           = 1'b1;
      bus.cmd_data  = 8'h00;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rst_ui_in", {24'd0, bus.ram_ui_in}, 32'd0);
      check("rst_uio_in", {24'd0, bus.ram_uio_in}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
      check("rst_state", {29'd0, bus.dbg_state}, {29'd0, IDLE});
      check("rst_ram_rst_n_low", {31'd0, bus.ram_rst_n}, 32'd0);
      rst = 1'b0;
      #1;
      check("ram_rst_n_high", {31'd0, bus.ram_rst_n}, 32'd1);
      @(posedge clk); #1;

      // Write 85,03,AA,BB,CC,DD -> addresses 5..8
      clear_obs();
      wdata[0] = 8'hAA; wdata[1] = 8'hBB; wdata[2] = 8'hCC; wdata[3] = 8'hDD;
      write_frame(7'd5, 8'h03);
      wait_idle(50, cyc);
      lit_wr[0] = {7'd5, 8'hAA}; lit_wr[1] = {7'd6, 8'hBB};
      lit_wr[2] = {7'd7, 8'hCC}; lit_wr[3] = {7'd8, 8'hDD};
      check("wr_count", obs_wr_q.size(), 32'd4);
      if (obs_wr_q.size() >= 4)
         for (int i = 0; i < 4; i++) check("wr_literal", {17'd0, obs_wr_q[i]}, {17'd0, lit_wr[i]});
      check("wr_end_busy", {31'd0, bus.busy}, 32'd0);

      // Wrap: write at 126, L=2; read back
      clear_obs();
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
      write_frame(7'd126, 8'h02);
      wait_idle(50, cyc);
      lit_wr[0] = {7'd126, 8'h11}; lit_wr[1] = {7'd127, 8'h22}; lit_wr[2] = {7'd0, 8'h33};
      check("wrap_wr_count", obs_wr_q.size(), 32'd3);
      if (obs_wr_q.size() >= 3)
         for (int i = 0; i < 3; i++) check("wrap_wr_literal", {17'd0, obs_wr_q[i]}, {17'd0, lit_wr[i]});
      read_frame(7'd126, 8'h02);
      wait_idle(100, cyc);
      check("read_throughput_cycles", cyc, 3 * (RD_LAT + 2));
      lit_rsp[0] = 8'h11; lit_rsp[1] = 8'h22; lit_rsp[2] = 8'h33;
      check("wrap_rsp_count", obs_rsp_q.size(), 32'd3);
      if (obs_rsp_q.size() >= 3)
         for (int i = 0; i < 3; i++) check("wrap_rsp_literal", {24'd0, obs_rsp_q[i]}, {24'd0, lit_rsp[i]});

      // Back-pressure: read 05,03 with rsp_ready low for 10 cycles per byte
      clear_obs();
      bus.rsp_ready = 1'b0;
      read_frame(7'd5, 8'h03);
      for (int b = 0; b < 4; b++) begin
         cyc = 0;
         while (!bus.rsp_valid && cyc < 20) begin
            check("bp_cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
         end
         if (!bus.rsp_valid) fail_now("bp_rsp_valid");
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_cmd_ready_hold", {31'd0, bus.cmd_ready}, 32'd0);
         end
         bus.rsp_ready = 1'b1;
         @(posedge clk); #1;
         bus.rsp_ready = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      wait_idle(50, cyc);
      lit_rsp[0] = 8'hAA; lit_rsp[1] = 8'hBB; lit_rsp[2] = 8'hCC; lit_rsp[3] = 8'hDD;
      check("bp_rsp_count", obs_rsp_q.size(), 32'd4);
      if (obs_rsp_q.size() >= 4)
         for (int i = 0; i < 4; i++) check("bp_rsp_literal", {24'd0, obs_rsp_q[i]}, {24'd0, lit_rsp[i]});

      // Abort: reset while the 2nd data byte of a 4-byte write is offered
      clear_obs();
      send_byte(8'hA0);
      send_byte(8'h03);
      exp_q.push_back({7'h20, 8'h5A});
      ref_mem[7'h20] = 8'h5A;
      send_byte(8'h5A);
      bus.cmd_data  = 8'h6B;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;          // WR_ISSUE of the first byte
      rst = 1'b1;
      @(posedge clk); #1;          // reset edge instead of accepting 6B
      check("abort_we_low", {31'd0, bus.ram_ui_in[7]}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_state", {29'd0, bus.dbg_state}, {29'd0, IDLE});
      check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_wr_count", obs_wr_q.size(), 32'd1);
      read_frame(7'h20, 8'h01);
      wait_idle(50, cyc);
      check("abort_rsp_count", obs_rsp_q.size(), 32'd2);
      if (obs_rsp_q.size() >= 2) begin
         check("abort_rsp_first", {24'd0, obs_rsp_q[0]}, 32'h5A);
         check("abort_rsp_second", {24'd0, obs_rsp_q[1]}, 32'h00);
      end

      // Max burst: L=FF write of pattern i from address 0, then read back
      clear_obs();
      for (int i = 0; i < 256; i++) wdata[i] = 8'(i);
      write_frame(7'd0, 8'hFF);
      wait_idle(1000, cyc);
      check("max_wr_count", obs_wr_q.size(), 32'd256);
      if (obs_wr_q.size() >= 256) begin
         check("max_wr_128", {17'd0, obs_wr_q[128]}, {17'd0, 7'd0, 8'd128});
         check("max_wr_255", {17'd0, obs_wr_q[255]}, {17'd0, 7'd127, 8'd255});
      end
      read_frame(7'd0, 8'hFF);
      wait_idle(2000, cyc);
      check("max_rsp_count", obs_rsp_q.size(), 32'd256);
      if (obs_rsp_q.size() >= 256) begin
         check("max_rsp_0", {24'd0, obs_rsp_q[0]}, 32'd128);
         check("max_rsp_127", {24'd0, obs_rsp_q[127]}, 32'd255);
         check("max_rsp_128", {24'd0, obs_rsp_q[128]}, 32'd128);
         check("max_rsp_255", {24'd0, obs_rsp_q[255]}, 32'd255);
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
